// File: rtl/shop_port_arbiter_v_pkg.sv
// Shared definitions for the shop_v command-port arbiter: default sizes,
// end-of-dialogue prompt and flush word (right-justified ASCII), FSM states.
package shop_port_arbiter_v_pkg;

   localparam int unsigned NUM_TERM_DEF     = 4;
   localparam int unsigned I_U_BITS_DEF     = 4;
   localparam int unsigned I_A_BITS_DEF     = 56;
   localparam int unsigned O_A_BITS_DEF     = 72;
   localparam int unsigned RSP_WAIT_DEF     = 4;
   localparam int unsigned IDLE_TIMEOUT_DEF = 64;
   localparam int unsigned FLUSH_MAX_DEF    = 4;

   localparam logic [31:0] PROMPT_ASCII = 32'h436d_643f;  // "Cmd?"
   localparam logic [31:0] FLUSH_ASCII  = 32'h4e4f_4e45;  // "NONE"

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT,
      ST_RESP,
      ST_HOLD,
      ST_FLUSH
   } arb_state_t;

endpackage

// File: rtl/shop_rr_pick_v.sv
// Combinational round-robin picker: scans req starting at ptr and returns the
// first requester as a one-hot grant plus its index.
//  req    in  NUM_TERM  request vector
//  ptr    in  PTR_W     index scanned first
//  gnt_c  out NUM_TERM  one-hot winner, 0 when no request
//  idx_c  out PTR_W     index of the winner (0 when no request)
module shop_rr_pick_v #(
   parameter  int unsigned NUM_TERM = 4,
   localparam int unsigned PTR_W    = $clog2(NUM_TERM)
) (
   input  logic [NUM_TERM-1:0] req,
   input  logic [PTR_W-1:0]    ptr,
   output logic [NUM_TERM-1:0] gnt_c,
   output logic [PTR_W-1:0]    idx_c
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] k;
   logic             found;

   // ptr and i are both below NUM_TERM, so one conditional subtract wraps the sum
   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      found = 1'b0;
      sum   = '0;
      k     = '0;
      for (int i = 0; i < NUM_TERM; i++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(NUM_TERM)) sum = sum - (PTR_W+1)'(NUM_TERM);
         k = PTR_W'(sum);
         if (!found && req[k]) begin
            found    = 1'b1;
            gnt_c[k] = 1'b1;
            idx_c    = k;
         end
      end
   end

endmodule

// File: rtl/shop_port_arbiter_v.sv
// Shares the single shop_v command port between NUM_TERM terminals. One
// terminal holds the lock for a whole dialogue, until the shop answers with
// the prompt; an owner that goes silent is flushed back to the prompt.
//  i_clk, i_reset        clock, async active-high reset
//  i_req/i_term_u/i_term_a  per-terminal word requests and payloads (flat)
//  o_gnt, o_ack, o_rsp_vld  per-terminal lock owner, capture pulse, response pulse
//  o_rsp_a               last captured shop response
//  o_err                 sticky flush failure
//  o_shop_rdy/u/a, i_shop_a  shop_v command port
module shop_port_arbiter_v
   import shop_port_arbiter_v_pkg::*;
#(
   parameter int unsigned NUM_TERM     = NUM_TERM_DEF,
   parameter int unsigned I_U_NUM_BITS = I_U_BITS_DEF,
   parameter int unsigned I_A_NUM_BITS = I_A_BITS_DEF,
   parameter int unsigned O_A_NUM_BITS = O_A_BITS_DEF,
   parameter int unsigned RSP_WAIT     = RSP_WAIT_DEF,
   parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
   parameter int unsigned FLUSH_MAX    = FLUSH_MAX_DEF,
   parameter logic [31:0] PROMPT       = PROMPT_ASCII,
   parameter logic [31:0] FLUSH_WORD   = FLUSH_ASCII
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_TERM-1:0]              i_req,
   input  logic [NUM_TERM*I_U_NUM_BITS-1:0] i_term_u,
   input  logic [NUM_TERM*I_A_NUM_BITS-1:0] i_term_a,
   output logic [NUM_TERM-1:0]              o_gnt,
   output logic [NUM_TERM-1:0]              o_ack,
   output logic [NUM_TERM-1:0]              o_rsp_vld,
   output logic [O_A_NUM_BITS-1:0]          o_rsp_a,
   output logic                             o_err,
   output logic                             o_shop_rdy,
   output logic [I_U_NUM_BITS-1:0]          o_shop_u,
   output logic [I_A_NUM_BITS-1:0]          o_shop_a,
   input  logic [O_A_NUM_BITS-1:0]          i_shop_a
);

   localparam int unsigned PTR_W   = $clog2(NUM_TERM);
   localparam int unsigned WAIT_W  = 4;
   localparam int unsigned IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
   localparam int unsigned FLUSH_W = $clog2(FLUSH_MAX + 1);

   arb_state_t          state;
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    owner_idx;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [IDLE_W-1:0]   idle_cnt;
   logic [FLUSH_W-1:0]  flush_cnt;
   logic                flushing;

   logic [NUM_TERM-1:0]     pick_gnt;
   logic [PTR_W-1:0]        pick_idx;
   logic [PTR_W-1:0]        sel_idx;
   logic [I_U_NUM_BITS-1:0] sel_u;
   logic [I_A_NUM_BITS-1:0] sel_a;
   logic                    owner_req;
   logic                    prompt_seen;
   logic [PTR_W-1:0]        next_ptr;

   shop_rr_pick_v #(.NUM_TERM(NUM_TERM)) u_pick (
      .req   (i_req),
      .ptr   (rr_ptr),
      .gnt_c (pick_gnt),
      .idx_c (pick_idx)
   );

   // Payload of the terminal being captured: the round-robin winner in IDLE, the owner otherwise
   always_comb begin
      sel_idx = (state == ST_IDLE) ? pick_idx : owner_idx;
      sel_u   = '0;
      sel_a   = '0;
      for (int k = 0; k < NUM_TERM; k++) begin
         if (PTR_W'(k) == sel_idx) begin
            sel_u = i_term_u[k*I_U_NUM_BITS +: I_U_NUM_BITS];
            sel_a = i_term_a[k*I_A_NUM_BITS +: I_A_NUM_BITS];
         end
      end
      owner_req   = i_req[owner_idx];
      prompt_seen = (o_rsp_a == O_A_NUM_BITS'(PROMPT));
      next_ptr    = (owner_idx == PTR_W'(NUM_TERM - 1)) ? '0 : owner_idx + PTR_W'(1);
   end

   // Dialogue FSM with registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         owner_idx  <= '0;
         wait_cnt   <= '0;
         idle_cnt   <= '0;
         flush_cnt  <= '0;
         flushing   <= 1'b0;
         o_gnt      <= '0;
         o_ack      <= '0;
         o_rsp_vld  <= '0;
         o_rsp_a    <= '0;
         o_err      <= 1'b0;
         o_shop_rdy <= 1'b0;
         o_shop_u   <= '0;
         o_shop_a   <= '0;
      end else begin
         o_ack     <= '0;
         o_rsp_vld <= '0;
         case (state)
            ST_IDLE: begin
               if (|i_req) begin
                  o_gnt     <= pick_gnt;
                  owner_idx <= pick_idx;
                  o_shop_u  <= sel_u;
                  o_shop_a  <= sel_a;
                  o_ack     <= pick_gnt;
                  flushing  <= 1'b0;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               o_shop_rdy <= 1'b1;
               state      <= ST_PULSE;
            end
            ST_PULSE: begin
               o_shop_rdy <= 1'b0;
               wait_cnt   <= '0;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_W'(RSP_WAIT - 1)) begin
                  o_rsp_a <= i_shop_a;
                  // flush answers are internal to the arbiter
                  if (!flushing) o_rsp_vld <= o_gnt;
                  state <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_RESP: begin
               if (prompt_seen) begin
                  o_gnt  <= '0;
                  rr_ptr <= next_ptr;
                  state  <= ST_IDLE;
               end else if (!flushing) begin
                  idle_cnt <= '0;
                  state    <= ST_HOLD;
               end else if (flush_cnt == FLUSH_W'(FLUSH_MAX)) begin
                  o_err  <= 1'b1;
                  o_gnt  <= '0;
                  rr_ptr <= next_ptr;
                  state  <= ST_IDLE;
               end else begin
                  state <= ST_FLUSH;
               end
            end
            ST_HOLD: begin
               // owner request beats a timeout landing in the same cycle
               if (owner_req) begin
                  o_shop_u <= sel_u;
                  o_shop_a <= sel_a;
                  o_ack    <= o_gnt;
                  state    <= ST_SETUP;
               end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                  flushing  <= 1'b1;
                  flush_cnt <= '0;
                  state     <= ST_FLUSH;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            ST_FLUSH: begin
               o_shop_u  <= '0;
               o_shop_a  <= I_A_NUM_BITS'(FLUSH_WORD);
               flush_cnt <= flush_cnt + FLUSH_W'(1);
               state     <= ST_SETUP;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shop_port_arbiter_v.sv
// Directed bench for shop_port_arbiter_v with a small behavioural shop model.
module tb_shop_port_arbiter_v;

   localparam int NT = 4;
   localparam int UW = 4;
   localparam int AW = 56;
   localparam int OW = 72;

   logic                clk = 1'b0;
   logic                rst;
   logic [NT-1:0]       req;
   logic [NT*UW-1:0]    term_u;
   logic [NT*AW-1:0]    term_a;
   logic [NT-1:0]       gnt, ack, rsp_vld;
   logic [OW-1:0]       rsp_a;
   logic                err;
   logic                shop_rdy;
   logic [UW-1:0]       shop_u;
   logic [AW-1:0]       shop_a_out;
   logic [OW-1:0]       shop_a_in = '0;

   always #5 clk = ~clk;

   shop_port_arbiter_v dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_req      (req),
      .i_term_u   (term_u),
      .i_term_a   (term_a),
      .o_gnt      (gnt),
      .o_ack      (ack),
      .o_rsp_vld  (rsp_vld),
      .o_rsp_a    (rsp_a),
      .o_err      (err),
      .o_shop_rdy (shop_rdy),
      .o_shop_u   (shop_u),
      .o_shop_a   (shop_a_out),
      .i_shop_a   (shop_a_in)
   );

   // Shop model: command word opens a dialogue, words count down to the prompt
   int          left = 0;
   logic        stuck = 1'b0;
   int          rdy_cnt = 0;
   logic [AW-1:0] last_word = '0;
   logic [UW-1:0] last_u = '0;
   int          ack_cnt [NT] = '{default: 0};
   int          rsp_cnt [NT] = '{default: 0};

   always @(posedge clk) begin
      if (rst) begin
         left <= 0;
      end else if (shop_rdy) begin
         rdy_cnt   <= rdy_cnt + 1;
         last_word <= shop_a_out;
         last_u    <= shop_u;
         if (stuck) shop_a_in <= 72'("Err");
         else if (shop_a_out == 56'("Login"))  begin left <= 2; shop_a_in <= 72'("Name?"); end
         else if (shop_a_out == 56'("AddUsr")) begin left <= 3; shop_a_in <= 72'("Name?"); end
         else if (shop_a_out == 56'("NONE"))   begin left <= 0; shop_a_in <= 72'("Cmd?"); end
         else if (left > 1) begin left <= left - 1; shop_a_in <= 72'("Next?"); end
         else begin left <= 0; shop_a_in <= 72'("Cmd?"); end
      end
      for (int k = 0; k < NT; k++) begin
         if (ack[k])     ack_cnt[k] <= ack_cnt[k] + 1;
         if (rsp_vld[k]) rsp_cnt[k] <= rsp_cnt[k] + 1;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_term(input int k, input logic [UW-1:0] u, input logic [AW-1:0] w);
      term_u[k*UW +: UW] = u;
      term_a[k*AW +: AW] = w;
   endtask

   task automatic wait_ack(input int k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (ack[k]) ok = 1'b1;
      end
      if (ok) req[k] = 1'b0;
   endtask

   task automatic wait_rsp(input int k, output logic [OW-1:0] rsp);
      bit seen;
      seen = 1'b0;
      rsp  = 'x;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (rsp_vld[k]) begin
            seen = 1'b1;
            rsp  = rsp_a;
         end
      end
   endtask

   task automatic send_word(input int k, input logic [UW-1:0] u, input logic [AW-1:0] w,
                            input logic [OW-1:0] exp, input string tag);
      bit ok;
      logic [OW-1:0] rsp;
      @(negedge clk);
      set_term(k, u, w);
      req[k] = 1'b1;
      wait_ack(k, ok);
      check({tag, " ack"}, OW'(ok), OW'(1));
      wait_rsp(k, rsp);
      check({tag, " rsp"}, rsp, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int s0, s1, r0;
      logic [OW-1:0] rsp;

      rst = 1'b1; req = '0; term_u = '0; term_a = '0;
      repeat (3) @(negedge clk);
      check("rst gnt",     OW'(gnt), OW'(0));
      check("rst shop_rdy", OW'(shop_rdy), OW'(0));
      check("rst rsp_a",   rsp_a, OW'(0));
      check("rst shop_a",  OW'(shop_a_out), OW'(0));
      check("rst err",     OW'(err), OW'(0));
      rst = 1'b0;

      // 1: T0 full Login dialogue
      s0 = ack_cnt[0]; s1 = rsp_cnt[0];
      send_word(0, 4'd1, 56'("Login"), 72'("Name?"), "t1 login");
      check("t1 gnt hold", OW'(gnt), OW'(4'b0001));
      send_word(0, 4'd2, 56'("Adm"), 72'("Next?"), "t1 adm");
      send_word(0, 4'd3, 56'("123"), 72'("Cmd?"), "t1 pw");
      @(negedge clk);
      check("t1 released", OW'(gnt), OW'(0));
      check("t1 ack cnt", OW'(ack_cnt[0] - s0), OW'(3));
      check("t1 rsp cnt", OW'(rsp_cnt[0] - s1), OW'(3));
      check("t1 last u",  OW'(last_u), OW'(3));

      // 2: T0 and T2 together with pointer 1 -> T2 first, T0 after release
      @(negedge clk);
      s0 = ack_cnt[0];
      set_term(0, 4'd1, 56'("Login"));
      set_term(2, 4'd5, 56'("Login"));
      req[0] = 1'b1; req[2] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (|ack) ok = 1'b1;
      end
      check("t2 ack", OW'(ack), OW'(4'b0100));
      check("t2 gnt", OW'(gnt), OW'(4'b0100));
      req[2] = 1'b0;
      wait_rsp(2, rsp);
      check("t2 t2 login rsp", rsp, 72'("Name?"));
      send_word(2, 4'd5, 56'("Adm"), 72'("Next?"), "t2 t2 adm");
      send_word(2, 4'd5, 56'("123"), 72'("Cmd?"), "t2 t2 pw");
      check("t2 t0 held off", OW'(ack_cnt[0] - s0), OW'(0));
      wait_ack(0, ok);
      check("t2 t0 ack", OW'(ok), OW'(1));
      check("t2 t0 gnt", OW'(gnt), OW'(4'b0001));
      wait_rsp(0, rsp);
      check("t2 t0 login rsp", rsp, 72'("Name?"));
      send_word(0, 4'd1, 56'("Adm"), 72'("Next?"), "t2 t0 adm");
      send_word(0, 4'd1, 56'("123"), 72'("Cmd?"), "t2 t0 pw");

      // 3: T1 waits while T0 runs an AddUsr dialogue
      send_word(0, 4'd1, 56'("AddUsr"), 72'("Name?"), "t3 addusr");
      @(negedge clk);
      s1 = ack_cnt[1];
      set_term(1, 4'd2, 56'("Login"));
      req[1] = 1'b1;
      send_word(0, 4'd1, 56'("Us1"), 72'("Next?"), "t3 us1");
      send_word(0, 4'd1, 56'("Ps1"), 72'("Next?"), "t3 ps1");
      send_word(0, 4'd1, 56'("SELLER"), 72'("Cmd?"), "t3 perm");
      check("t3 t1 held off", OW'(ack_cnt[1] - s1), OW'(0));
      wait_ack(1, ok);
      check("t3 t1 ack", OW'(ok), OW'(1));
      check("t3 t1 gnt", OW'(gnt), OW'(4'b0010));
      wait_rsp(1, rsp);
      check("t3 t1 rsp", rsp, 72'("Name?"));
      send_word(1, 4'd2, 56'("Adm"), 72'("Next?"), "t3 t1 adm");
      send_word(1, 4'd2, 56'("123"), 72'("Cmd?"), "t3 t1 pw");

      // 4: silent owner is flushed back to the prompt
      send_word(0, 4'd7, 56'("Login"), 72'("Name?"), "t4 login");
      @(negedge clk);
      r0 = rdy_cnt; s0 = rsp_cnt[0];
      repeat (59) @(negedge clk);
      check("t4 no early flush", OW'(rdy_cnt - r0), OW'(0));
      check("t4 still owned", OW'(gnt), OW'(4'b0001));
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (gnt == '0) ok = 1'b1;
      end
      check("t4 released", OW'(ok), OW'(1));
      check("t4 one flush", OW'(rdy_cnt - r0), OW'(1));
      check("t4 flush word", OW'(last_word), OW'(56'("NONE")));
      check("t4 flush u", OW'(last_u), OW'(0));
      check("t4 no rsp_vld", OW'(rsp_cnt[0] - s0), OW'(0));
      check("t4 err", OW'(err), OW'(0));

      // 5: shop never returns the prompt -> 4 flushes then sticky error
      stuck = 1'b1;
      send_word(1, 4'd2, 56'("Login"), 72'("Err"), "t5 login");
      @(negedge clk);
      r0 = rdy_cnt; s1 = rsp_cnt[1];
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (err) ok = 1'b1;
      end
      check("t5 err set", OW'(ok), OW'(1));
      check("t5 released", OW'(gnt), OW'(0));
      check("t5 four flushes", OW'(rdy_cnt - r0), OW'(4));
      check("t5 no rsp_vld", OW'(rsp_cnt[1] - s1), OW'(0));
      repeat (5) @(negedge clk);
      check("t5 err sticky", OW'(err), OW'(1));
      check("t5 no more words", OW'(rdy_cnt - r0), OW'(4));
      stuck = 1'b0;

      // 6: reset during PULSE drops rdy at once and clears the pointer
      @(negedge clk);
      set_term(3, 4'd4, 56'("Login"));
      req[3] = 1'b1;
      wait_ack(3, ok);
      check("t6 t3 ack", OW'(ok), OW'(1));
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (shop_rdy) ok = 1'b1;
      end
      check("t6 rdy seen", OW'(ok), OW'(1));
      rst = 1'b1;
      #1;
      check("t6 rdy dropped", OW'(shop_rdy), OW'(0));
      check("t6 gnt", OW'(gnt), OW'(0));
      check("t6 err", OW'(err), OW'(0));
      check("t6 rsp_a", rsp_a, OW'(0));
      check("t6 shop_a", OW'(shop_a_out), OW'(0));
      check("t6 shop_u", OW'(shop_u), OW'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      s0 = ack_cnt[2];
      set_term(1, 4'd1, 56'("Login"));
      set_term(2, 4'd2, 56'("Login"));
      req[1] = 1'b1; req[2] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (|ack) ok = 1'b1;
      end
      check("t6 lowest wins", OW'(ack), OW'(4'b0010));
      req[1] = 1'b0; req[2] = 1'b0;
      wait_rsp(1, rsp);
      check("t6 t1 rsp", rsp, 72'("Name?"));
      send_word(1, 4'd1, 56'("Adm"), 72'("Next?"), "t6 adm");
      send_word(1, 4'd1, 56'("123"), 72'("Cmd?"), "t6 pw");
      repeat (5) @(negedge clk);
      check("t6 dropped req unsent", OW'(ack_cnt[2] - s0), OW'(0));
      check("t6 idle gnt", OW'(gnt), OW'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
